mux_arbiter: RTL and testbench
==============================

Name: mux_arbiter

Overview:
- Two-requester arbiter that shares the 20-bit 2:1 select datapath between sources A and B.
- Each source offers words through a valid/ready handshake.
- The block arbitrates, drives the select line, and captures the selected word in a one-entry registered output stage.
- Arbitration is round-robin with a bounded burst allowance, so one streaming source cannot starve the other.

Parameters:
- WIDTH, 20, data width of A, B and D.
- MAX_BURST, 2, maximum consecutive transfers granted to one source while the other is also requesting; legal range 1..15.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- A  input  WIDTH  source A data.
- a_valid  input  1  source A offers A this cycle.
- a_ready  output  1  A accepted this cycle.
- B  input  WIDTH  source B data.
- b_valid  input  1  source B offers B this cycle.
- b_ready  output  1  B accepted this cycle.
- sel  output  1  select line: 0 = A, 1 = B; equals the current cycle's grant.
- D  output  WIDTH  registered output word.
- d_valid  output  1  D holds a word.
- d_ready  input  1  downstream accepts D this cycle.
- d_src  output  1  source of the word in D (0 = A, 1 = B).

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-low (clk, rst_n).
  - On rst_n low, immediately: D = 0, d_valid = 0, d_src = 0, owner = B, cnt = MAX_BURST.
  - The reset owner/cnt values make A win the first contested cycle.
- load_en = !d_valid || d_ready (combinational). The output register accepts a word only when load_en = 1.
- Grant, combinational, evaluated only when load_en = 1:
  - Neither valid: no grant; sel holds its previous value.
  - Exactly one valid: grant that source.
  - Both valid and cnt < MAX_BURST: grant owner.
  - Both valid and cnt >= MAX_BURST: grant the other source.
- Handshake outputs:
  - a_ready = load_en && a_valid && grant == A; b_ready is the mirror for B.
  - Never both ready in the same cycle. No ready is asserted when load_en = 0.
- Transfer on a grant, at the clock edge:
  - D <= selected word, d_valid <= 1, d_src <= grant.
  - If grant == owner: cnt <= cnt + 1, saturating at MAX_BURST.
  - Otherwise: owner <= grant, cnt <= 1.
- No grant while load_en = 1 and d_ready = 1: d_valid <= 0. D and d_src hold their old values.
- Latency:
  - A word accepted at edge N appears on D with d_valid at N+1.
  - Full throughput, one word per cycle, when d_ready is held high.
- State machine, encoded by {d_valid, d_src}:
  - IDLE (d_valid = 0).
  - HOLD_A (d_valid = 1, d_src = 0).
  - HOLD_B (d_valid = 1, d_src = 1).
  - Any state goes to HOLD_A or HOLD_B on a grant.
  - HOLD_x goes to IDLE on d_ready with no grant.
  - HOLD_x with !d_ready stays put: D, d_src, owner and cnt all frozen.
- Boundary conditions:
  - Back-pressure: with d_ready low while full, a_ready = b_ready = 0 regardless of valids. D stays stable.
  - Simultaneous pop and push (d_valid = 1, d_ready = 1, grant present): the new word replaces the old in the same edge, with no bubble.
  - A source deasserting valid mid-burst: the other source is granted per the single-valid rule. owner and cnt update as a normal transfer.
  - Counter saturation: cnt never exceeds MAX_BURST and never wraps.
  - MAX_BURST = 1 gives strict alternation under continuous contention.
  - Reset mid-transfer: a pending D word is discarded; no ready is asserted while rst_n is low.

Test Plan:
1. Reset, then a_valid = 1 with A = 20'h00001, b_valid = 0, d_ready = 1 -> a_ready = 1 and sel = 0 in the same cycle. Next cycle D = 20'h00001, d_valid = 1, d_src = 0.
2. MAX_BURST = 2, both valid continuously, d_ready = 1, A = 20'hA0000+n, B = 20'hB0000+n -> d_src sequence 0,0,1,1,0,0. No ready in any cycle for the non-granted source.
3. Both valid, d_ready = 0 for 4 cycles after the first load -> D holds 20'hA0000. a_ready = b_ready = 0 for 4 cycles. Release d_ready -> the next word is accepted in the same cycle.
4. Only B valid for 5 cycles -> 5 consecutive B transfers (cnt saturates at 2). Then A asserts while B is still valid -> A is granted on the next load.
5. Continuous traffic, pulse rst_n low asynchronously mid-cycle -> d_valid drops to 0 immediately. After release with both valid, A is granted first.
6. MAX_BURST = 1, both valid, d_ready toggling 1,0,1,0 -> d_src strictly alternates 0,1,0,1 across accepted words. No word is lost or duplicated (scoreboard check).

Source files
------------

// File: rtl/mux_arbiter.sv
// mux_arbiter: round-robin 2:1 arbiter with a bounded burst allowance,
// feeding a one-entry registered output stage with valid/ready handshakes.
module mux_arbiter #(
  parameter int WIDTH     = 20,
  parameter int MAX_BURST = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] B,
  input  logic             b_valid,
  output logic             b_ready,
  output logic             sel,
  output logic [WIDTH-1:0] D,
  output logic             d_valid,
  input  logic             d_ready,
  output logic             d_src
);
  localparam logic [3:0] MB = 4'(MAX_BURST);
  // IDLE keeps the last source bit so d_src holds across the drain
  typedef enum logic [1:0] {IDLE_A = 2'b00, IDLE_B = 2'b01, HOLD_A = 2'b10, HOLD_B = 2'b11} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             sel_q, sel_d, owner_q, owner_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             load_en, gnt, gnt_b;
  always_comb begin
    load_en = !state_q[1] || d_ready;
    gnt     = rst_n && load_en && (a_valid || b_valid);
    gnt_b   = (a_valid && b_valid) ? ((cnt_q < MB) ? owner_q : !owner_q) : b_valid;
    state_d = gnt ? (gnt_b ? HOLD_B : HOLD_A)
            : (state_q[1] && d_ready) ? (state_q[0] ? IDLE_B : IDLE_A) : state_q;
    d_d     = gnt ? (gnt_b ? B : A) : d_q;
    sel_d   = gnt ? gnt_b : sel_q;
    owner_d = gnt ? gnt_b : owner_q;
    cnt_d   = !gnt ? cnt_q : (gnt_b != owner_q) ? 4'd1 : (cnt_q >= MB) ? MB : cnt_q + 4'd1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE_A;
      d_q     <= '0;
      sel_q   <= 1'b0;
      owner_q <= 1'b1;
      cnt_q   <= MB;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      sel_q   <= sel_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end
  assign a_ready = gnt && !gnt_b;
  assign b_ready = gnt && gnt_b;
  assign sel     = sel_d;
  assign D       = d_q;
  assign d_valid = state_q[1];
  assign d_src   = state_q[0];
endmodule

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter: two arbiters (burst limits 2 and 1) on shared directed stimulus,
// checked every cycle against a behavioural model plus hand-computed literals.
module tb_mux_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] a_i = '0, b_i = '0;
  logic        av = 1'b0, bv = 1'b0, dr = 1'b0;
  logic [1:0]  ar, br, sl, dvo, dso;
  logic [19:0] dd [2];
  int pass_n = 0, tot_n = 0;
  int li = -1, x_ar = -1, x_br = -1, x_sel = -1, x_dv = -1, x_src = -1, x_d = -1;
  bit          m_dv [2], m_src [2], m_sel [2], m_last [2];
  int          m_run [2];
  logic [19:0] m_d [2];
  logic [19:0] sb [$];
  always #5 clk = ~clk;
  mux_arbiter #(.WIDTH(20), .MAX_BURST(2)) u0 (
    .clk(clk), .rst_n(rst_n), .A(a_i), .a_valid(av), .a_ready(ar[0]),
    .B(b_i), .b_valid(bv), .b_ready(br[0]), .sel(sl[0]), .D(dd[0]),
    .d_valid(dvo[0]), .d_ready(dr), .d_src(dso[0]));
  mux_arbiter #(.WIDTH(20), .MAX_BURST(1)) u1 (
    .clk(clk), .rst_n(rst_n), .A(a_i), .a_valid(av), .a_ready(ar[1]),
    .B(b_i), .b_valid(bv), .b_ready(br[1]), .sel(sl[1]), .D(dd[1]),
    .d_valid(dvo[1]), .d_ready(dr), .d_src(dso[1]));
  task automatic chk(input int i, input string n, input int got, input int exp);
    tot_n++;
    if (got == exp) pass_n++;
    else $display("FAIL u%0d %s: got %0h, expected %0h at %0t", i, n, got, exp, $time);
  endtask
  // model state: m_last/m_run = most recent granted source and its streak, capped at the burst limit
  always @(negedge clk) begin
    int mb;
    bit le, any, g, ear, ebr, esel;
    for (int i = 0; i < 2; i++) begin
      mb = (i == 0) ? 2 : 1;
      if (!rst_n) begin
        m_dv[i] = 0; m_d[i] = '0; m_src[i] = 0; m_sel[i] = 0; m_last[i] = 1; m_run[i] = mb;
        if (i == 1) sb.delete();
        chk(i, "rst a_ready", ar[i], 0);
        chk(i, "rst b_ready", br[i], 0);
        chk(i, "rst d_valid", dvo[i], 0);
        chk(i, "rst D", dd[i], 0);
        chk(i, "rst d_src", dso[i], 0);
        chk(i, "rst sel", sl[i], 0);
      end else begin
        le   = !m_dv[i] || dr;
        any  = le && (av || bv);
        g    = (av && bv) ? ((m_run[i] < mb) ? m_last[i] : !m_last[i]) : bv;
        ear  = any && !g;
        ebr  = any && g;
        esel = any ? g : m_sel[i];
        chk(i, "a_ready", ar[i], ear);
        chk(i, "b_ready", br[i], ebr);
        chk(i, "sel", sl[i], esel);
        chk(i, "d_valid", dvo[i], m_dv[i]);
        if (m_dv[i]) begin
          chk(i, "D", dd[i], m_d[i]);
          chk(i, "d_src", dso[i], m_src[i]);
        end
        if (li == i) begin
          if (x_ar >= 0) chk(i, "lit a_ready", ar[i], x_ar);
          if (x_br >= 0) chk(i, "lit b_ready", br[i], x_br);
          if (x_sel >= 0) chk(i, "lit sel", sl[i], x_sel);
          if (x_dv >= 0) chk(i, "lit d_valid", dvo[i], x_dv);
          if (x_src >= 0) chk(i, "lit d_src", dso[i], x_src);
          if (x_d >= 0) chk(i, "lit D", dd[i], x_d);
        end
        if (i == 1 && dvo[1] && dr) begin
          chk(1, "sb depth", sb.size(), 1);
          if (sb.size() > 0) begin
            chk(1, "sb word", dd[1], sb[0]);
            void'(sb.pop_front());
          end
        end
        if (any) begin
          m_d[i] = g ? b_i : a_i;
          m_dv[i] = 1;
          m_src[i] = g;
          m_sel[i] = g;
          if (i == 1) sb.push_back(m_d[i]);
          if (g == m_last[i]) m_run[i] = (m_run[i] + 1 > mb) ? mb : m_run[i] + 1;
          else begin
            m_last[i] = g;
            m_run[i] = 1;
          end
        end else if (dr) m_dv[i] = 0;
      end
    end
  end
  task automatic clr_lit();
    li = -1; x_ar = -1; x_br = -1; x_sel = -1; x_dv = -1; x_src = -1; x_d = -1;
  endtask
  task automatic step(input bit a_v, input int a, input bit b_v, input int b, input bit d_r);
    @(posedge clk);
    #2;
    av = a_v; a_i = a[19:0]; bv = b_v; b_i = b[19:0]; dr = d_r;
    clr_lit();
  endtask
  task automatic lit(input int i, input int e_ar, input int e_br, input int e_sel,
                     input int e_dv, input int e_src, input int e_d);
    li = i; x_ar = e_ar; x_br = e_br; x_sel = e_sel; x_dv = e_dv; x_src = e_src; x_d = e_d;
  endtask
  // reset asserted mid-cycle and held across one rising edge; keep=1 leaves traffic applied
  task automatic do_reset(input bit keep);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    clr_lit();
    if (!keep) begin
      av = 0; bv = 0; dr = 0;
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask
  initial begin
    bit [5:0] s2;
    int m;
    s2 = 6'b001100;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    // single A word
    step(1, 'h00001, 0, 0, 1); lit(0, 1, 0, 0, 0, -1, -1);
    step(0, 0, 0, 0, 1);       lit(0, 0, 0, 0, 1, 0, 'h00001);
    // continuous contention, burst 2
    do_reset(0);
    for (int n = 0; n < 6; n++) begin
      step(1, 'hA0000 + n, 1, 'hB0000 + n, 1);
      if (n == 0) lit(0, 1, 0, 0, 0, -1, -1);
      else lit(0, !s2[n], s2[n], s2[n], 1, s2[n-1], (s2[n-1] ? 'hB0000 : 'hA0000) + n - 1);
    end
    step(0, 0, 0, 0, 1); lit(0, 0, 0, -1, 1, 0, 'hA0005);
    // back-pressure
    do_reset(0);
    step(1, 'hA0000, 1, 'hB0000, 0); lit(0, 1, 0, 0, 0, -1, -1);
    for (int n = 0; n < 4; n++) begin
      step(1, 'hA0001, 1, 'hB0001, 0); lit(0, 0, 0, 0, 1, 0, 'hA0000);
    end
    step(1, 'hA0001, 1, 'hB0001, 1); lit(0, 1, 0, 0, 1, 0, 'hA0000);
    step(0, 0, 0, 0, 1);             lit(0, 0, 0, 0, 1, 0, 'hA0001);
    // B streams alone, then A joins
    do_reset(0);
    for (int n = 0; n < 5; n++) begin
      step(0, 0, 1, 'hB0010 + n, 1);
      if (n == 0) lit(0, 0, 1, 1, 0, -1, -1);
      else lit(0, 0, 1, 1, 1, 1, 'hB0010 + n - 1);
    end
    step(1, 'hA0020, 1, 'hB0015, 1); lit(0, 1, 0, 0, 1, 1, 'hB0014);
    step(0, 0, 0, 0, 1);             lit(0, 0, 0, 0, 1, 0, 'hA0020);
    // asynchronous reset in the middle of traffic
    do_reset(0);
    for (int n = 0; n < 3; n++) step(1, 'hA0030 + n, 1, 'hB0030 + n, 1);
    do_reset(1); lit(0, 1, 0, 0, 0, -1, -1);
    step(0, 0, 0, 0, 1); lit(0, 0, 0, 0, 1, 0, 'hA0032);
    // burst 1 with toggling d_ready
    do_reset(0);
    for (int n = 0; n < 8; n++) begin
      step(1, 'hA0100 + n, 1, 'hB0100 + n, (n % 2) == 0);
      m = n - (n % 2);
      if (n % 2 == 1)
        lit(1, 0, 0, (m % 4) == 2, 1, (m % 4) == 2, ((m % 4) == 2 ? 'hB0100 : 'hA0100) + m);
      else lit(1, (n % 4) == 0, (n % 4) == 2, (n % 4) == 2, n > 0, -1, -1);
    end
    step(0, 0, 0, 0, 1); lit(1, 0, 0, -1, 1, 1, 'hB0106);
    step(0, 0, 0, 0, 1);
    @(negedge clk);
    @(posedge clk);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
